// File: rtl/mrd_tag_pool.sv
// mrd_tag_pool: free-list based allocator for PCIe MRd tags on the S2C read path.
// Tags are handed out in FIFO order from a free list and are returned either
// one at a time by the completion demux or all at once by flush.
module mrd_tag_pool #(
   parameter int NUM_TAGS = 32,
   parameter int TAG_BASE = 0,
   parameter int CNT_W    = $clog2(NUM_TAGS) + 1
) (
   input  logic             s_axi_clk,
   input  logic             s_axi_rstn,
   input  logic             alloc_tag_req,
   output logic             allocated_tag_rdy,
   output logic [7:0]       allocated_tag,
   input  logic             free_tag_valid,
   input  logic [7:0]       free_tag,
   input  logic             flush,
   output logic [CNT_W-1:0] tags_in_use,
   output logic             pool_empty,
   output logic             free_err
);

   localparam int               PTR_W    = $clog2(NUM_TAGS);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAGS);

   // free list and its bookkeeping
   logic [7:0]          r_fifo [NUM_TAGS];
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [CNT_W-1:0]    r_free_cnt;
   logic [NUM_TAGS-1:0] r_in_use;

   // registered outputs
   logic                r_rdy;
   logic [7:0]          r_tag;
   logic [CNT_W-1:0]    r_tags_in_use;
   logic                r_pool_empty;
   logic                r_free_err;

   logic                w_grant;
   logic                w_legal;
   logic [7:0]          w_gnt_tag;
   logic [NUM_TAGS-1:0] w_gnt_hit;
   logic [NUM_TAGS-1:0] w_free_hit;
   logic [CNT_W-1:0]    w_cnt_nxt;

   assign w_gnt_tag = r_fifo[r_rd_ptr];

   // The rdy term spaces grants two cycles apart so a requestor that drops
   // its request on seeing rdy cannot be granted twice.
   assign w_grant = alloc_tag_req & (r_free_cnt != '0) & ~r_rdy & ~flush;

   // Per-slot tag decode: comparing the full 8-bit tag against each slot's
   // value makes the range check implicit (an out-of-range tag hits no slot).
   for (genvar j = 0; j < NUM_TAGS; j++) begin : g_slot
      assign w_gnt_hit[j]  = (w_gnt_tag == 8'(TAG_BASE + j));
      assign w_free_hit[j] = (free_tag  == 8'(TAG_BASE + j));
   end

   // A release is legal only for an in-range tag that is currently allocated.
   // A tag granted in this same cycle is not yet marked, so it is rejected.
   assign w_legal = free_tag_valid & (|(w_free_hit & r_in_use));

   // occupancy next state: +1 on legal free, -1 on grant, both cancel
   always_comb begin
      w_cnt_nxt = r_free_cnt;
      case ({w_grant, w_legal})
         2'b10:   w_cnt_nxt = r_free_cnt - 1'b1;
         2'b01:   w_cnt_nxt = r_free_cnt + 1'b1;
         default: w_cnt_nxt = r_free_cnt;
      endcase
   end

   // free-list storage: reload identity contents on reset/flush, append frees
   always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
      if (!s_axi_rstn) begin
         for (int i = 0; i < NUM_TAGS; i++) r_fifo[i] <= 8'(TAG_BASE + i);
      end else if (flush) begin
         for (int i = 0; i < NUM_TAGS; i++) r_fifo[i] <= 8'(TAG_BASE + i);
      end else if (w_legal) begin
         r_fifo[r_wr_ptr] <= free_tag;
      end
   end

   // pointers and free count; pointers wrap naturally at NUM_TAGS
   always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
      if (!s_axi_rstn) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_free_cnt <= FULL_CNT;
      end else if (flush) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_free_cnt <= FULL_CNT;
      end else begin
         if (w_grant) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_legal) r_wr_ptr <= r_wr_ptr + 1'b1;
         r_free_cnt <= w_cnt_nxt;
      end
   end

   // in-use bitmap: set on grant, clear on legal release (never the same slot)
   always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
      if (!s_axi_rstn) begin
         r_in_use <= '0;
      end else if (flush) begin
         r_in_use <= '0;
      end else begin
         r_in_use <= (r_in_use | (w_grant ? w_gnt_hit : '0))
                              & ~(w_legal ? w_free_hit : '0);
      end
   end

   // grant pulse and held tag value
   always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
      if (!s_axi_rstn) begin
         r_rdy <= 1'b0;
         r_tag <= '0;
      end else begin
         r_rdy <= w_grant;
         if (w_grant) r_tag <= w_gnt_tag;
      end
   end

   // status outputs track the free count on the same edge that updates it
   always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
      if (!s_axi_rstn) begin
         r_tags_in_use <= '0;
         r_pool_empty  <= 1'b0;
         r_free_err    <= 1'b0;
      end else if (flush) begin
         r_tags_in_use <= '0;
         r_pool_empty  <= 1'b0;
         r_free_err    <= 1'b0;
      end else begin
         r_tags_in_use <= FULL_CNT - w_cnt_nxt;
         r_pool_empty  <= (w_cnt_nxt == '0);
         r_free_err    <= free_tag_valid & ~w_legal;
      end
   end

   assign allocated_tag_rdy = r_rdy;
   assign allocated_tag     = r_tag;
   assign tags_in_use       = r_tags_in_use;
   assign pool_empty        = r_pool_empty;
   assign free_err          = r_free_err;

endmodule

// File: doc/mrd_tag_pool.md
# mrd_tag_pool

Tag allocator for the S2C read path. It owns a pool of PCIe MRd tags and hands one to each channel's MRd requestor on its `alloc_tag_req` / `allocated_tag_rdy` / `allocated_tag` handshake. It takes a tag back when the read-completion path reports the last completion for that tag. It sits directly upstream of the S2C channel's tag allocation port, and its free port is driven from the completion demux.

## Interface
Parameters:
- `NUM_TAGS`, default 32: pool size. Power of 2, 2..256.
- `TAG_BASE`, default 0: first tag value. Tags span `TAG_BASE .. TAG_BASE+NUM_TAGS-1`. `TAG_BASE+NUM_TAGS` ≤ 256.
- `CNT_W`, default `$clog2(NUM_TAGS)+1`: width of the occupancy counter.

Ports:
- `s_axi_clk` in 1: single clock for all logic.
- `s_axi_rstn` in 1: asynchronous, active-low reset.
- `alloc_tag_req` in 1: level request from the MRd requestor. Held until `allocated_tag_rdy` is seen.
- `allocated_tag_rdy` out 1: one-cycle grant pulse.
- `allocated_tag` out 8: granted tag. Valid while `allocated_tag_rdy`=1, held otherwise.
- `free_tag_valid` in 1: one-cycle tag release strobe (completion last-in-burst for this tag).
- `free_tag` in 8: tag being released.
- `flush` in 1: synchronous return of all tags (channel stop/abort).
- `tags_in_use` out CNT_W: number of tags currently allocated.
- `pool_empty` out 1: no free tag available.
- `free_err` out 1: one-cycle pulse on an illegal release.

## Operation
- **Storage.** A free-list FIFO of `NUM_TAGS` x 8-bit entries, with `rd_ptr`/`wr_ptr` of `$clog2(NUM_TAGS)` bits that wrap naturally. A `free_cnt` counter of CNT_W bits, and an `in_use[NUM_TAGS]` bitmap.
- **Reset and flush state.** Entry i = `TAG_BASE+i`, `rd_ptr`=`wr_ptr`=0, `free_cnt`=`NUM_TAGS`, `in_use`=0. `flush` loads this same state on the next edge and overrides any alloc or free in that cycle. `allocated_tag_rdy` is 0 in the cycle after a flush.
- **Grant condition**, evaluated each cycle: `alloc_tag_req` & (`free_cnt`≠0) & !`allocated_tag_rdy` & !`flush`. On a grant, at the next edge:
  - `allocated_tag` ← `fifo[rd_ptr]`
  - `allocated_tag_rdy` ← 1
  - `rd_ptr`++
  - `in_use[tag-TAG_BASE]` ← 1
- **Grant rate.** The `!allocated_tag_rdy` term limits grants to at most one every 2 cycles, so a requestor that drops `alloc_tag_req` the cycle after it sees rdy never gets a double grant.
- **Legal release.** Condition: `free_tag_valid` & (`free_tag-TAG_BASE` < `NUM_TAGS`, unsigned 8-bit subtract) & `in_use[idx]`. On a legal release:
  - `fifo[wr_ptr]` ← `free_tag`
  - `wr_ptr`++
  - `in_use[idx]` ← 0
- **Illegal release** (out of range, or tag not in use): nothing changes, `free_err` pulses for 1 cycle.
- **Counter update.**
  - `free_cnt` += legal_free − grant.
  - Simultaneous grant and legal free: `free_cnt` is unchanged and both pointers advance.
- **Freed tag reuse.** A tag freed in cycle N is written to the FIFO at the edge ending N. There is no bypass, so it is grantable in cycle N+1 at the earliest.
- **Release of the tag being granted in the same cycle.** The bitmap is not yet set, so this is an illegal release: `free_err` pulses, and the tag stays allocated.
- **Derived outputs.** `tags_in_use` = `NUM_TAGS` − `free_cnt`, registered. `pool_empty` = (`free_cnt`==0), registered.
- **Empty pool with a request pending.** `alloc_tag_req` waits. No state changes until a legal free arrives.

## Timing
- **Reset values:**
  - `allocated_tag_rdy`=0
  - `allocated_tag`=0
  - `tags_in_use`=0
  - `pool_empty`=0
  - `free_err`=0
- **Grant latency.** `alloc_tag_req` rises in cycle N with the pool non-empty and no rdy in cycle N → `allocated_tag_rdy`=1 in cycle N+1.
- **Free-to-grant latency** with an empty pool and the request held: free in cycle N → rdy in cycle N+2.
- **Status lag.** `tags_in_use` and `pool_empty` lag the causing edge by 0 cycles: they are updated on the same edge as `free_cnt`.
- **`free_err` timing.** Asserted in the cycle after the offending strobe.
- **Reset mid-operation.** Asynchronous assertion returns to the full-pool state immediately. An outstanding grant pulse is cancelled.
- **Wrap-around.** Pointers wrap modulo `NUM_TAGS`. `free_cnt` never exceeds `NUM_TAGS`, because the bitmap check prevents over-release.

## Test plan
- **Sequential grants.** Reset, hold `alloc_tag_req` high for 70 cycles with `NUM_TAGS`=32 and `TAG_BASE`=0 → 32 rdy pulses on alternate cycles with tags 0,1,…,31. Then `pool_empty`=1, `tags_in_use`=32, and no further rdy.
- **Free then regrant.** From the empty pool, free tag 17 in cycle N with the request held → rdy in cycle N+2 with tag 17, `pool_empty` back to 1.
- **Simultaneous grant and free.** With 5 tags allocated, a grant and a free of tag 2 in the same cycle → `tags_in_use` stays 5, and tag 2 is reissued only after the remaining 26 free tags.
- **Illegal releases.** Free tag 40 (out of range) → `free_err` pulse, counts unchanged. Free tag 3 while it is not allocated → `free_err` pulse. Free tag 3 twice → first release legal, second pulses `free_err`.
- **Flush.** With 20 tags allocated and `alloc_tag_req` high, pulse `flush` → next cycle `tags_in_use`=0 and no rdy. The following grant returns tag 0.
- **Async reset mid-grant.** Assert `s_axi_rstn`=0 in the cycle `allocated_tag_rdy`=1 → rdy drops immediately, all outputs reach their reset values, and the first grant after release is tag `TAG_BASE`.
